// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head into the regfile, handshakes stores
// with the LSB, and raises flush/redirect on mispredicts. Optional counter: COMMIT_STAT_EN.
module commit_ctrl #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [ROB_WIDTH-1:0] head_rob_id,
  input  logic [1:0]           head_type,
  input  logic [4:0]           head_rd,
  input  logic [31:0]          head_val,
  input  logic                 head_mispredict,
  input  logic [31:0]          head_target,
  output logic                 pop,
  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 store_req,
  output logic [ROB_WIDTH-1:0] store_rob_id,
  input  logic                 store_done,
  output logic                 clear,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 halt,
  output logic [31:0]          commit_count
);

  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH, HALTED} state_t;

  state_t state, state_nxt;
  logic   eligible;
  logic   active;
  logic   mispredict_pop;
  logic   halt_pop;

  assign eligible = head_valid && head_ready;
  assign active   = rdy_in && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= RUN;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (eligible) begin
          case (head_type)
            2'd1:    state_nxt = STORE_WAIT;
            2'd2:    if (head_mispredict) state_nxt = FLUSH;
            2'd3:    state_nxt = HALTED;
            default: state_nxt = RUN;
          endcase
        end
      end
      STORE_WAIT: if (store_done) state_nxt = RUN;
      FLUSH:      state_nxt = RUN;
      default:    state_nxt = HALTED;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    commit_ready = 1'b0;
    store_req    = 1'b0;
    if (active) begin
      case (state)
        RUN: begin
          if (eligible) begin
            case (head_type)
              2'd0, 2'd2: begin
                pop          = 1'b1;
                commit_ready = (head_rd != 5'd0);
              end
              2'd1:    store_req = 1'b1;
              default: pop = 1'b1;
            endcase
          end
        end
        STORE_WAIT: pop = store_done;
        default: ;
      endcase
    end
    commit_reg_id = commit_ready ? head_rd     : '0;
    commit_val    = commit_ready ? head_val    : '0;
    commit_rob_id = commit_ready ? head_rob_id : '0;
  end

  // pop already implies RUN-with-eligible-head for these two types
  assign mispredict_pop = pop && (state == RUN) && (head_type == 2'd2) && head_mispredict;
  assign halt_pop       = pop && (state == RUN) && (head_type == 2'd3);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clear          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      halt           <= 1'b0;
      store_rob_id   <= '0;
    end else if (rdy_in) begin
      clear          <= mispredict_pop;
      redirect_valid <= mispredict_pop;
      if (mispredict_pop) redirect_pc  <= head_target;
      if (store_req)      store_rob_id <= head_rob_id;
      if (halt_pop)       halt         <= 1'b1;
    end
  end

`ifdef COMMIT_STAT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)   count_q <= '0;
    else if (pop) count_q <= count_q + 32'd1;
  end

  assign commit_count = count_q;
`else
  assign commit_count = '0;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: directed scenarios plus a randomized run
// against a flag-based behavioural model of the commit rules.
module tb_commit_ctrl;

  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, head_valid, head_ready, head_mispredict, store_done;
  logic [RW-1:0] head_rob_id;
  logic [1:0]    head_type;
  logic [4:0]    head_rd;
  logic [31:0]   head_val, head_target;
  logic          pop, commit_ready, store_req, clear, redirect_valid, halt;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val, redirect_pc, commit_count;
  logic [RW-1:0] commit_rob_id, store_rob_id;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk_in = ~clk_in;

  commit_ctrl #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_ready(head_ready), .head_rob_id(head_rob_id),
    .head_type(head_type), .head_rd(head_rd), .head_val(head_val),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .pop(pop), .commit_ready(commit_ready), .commit_reg_id(commit_reg_id),
    .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .store_req(store_req), .store_rob_id(store_rob_id), .store_done(store_done),
    .clear(clear), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .commit_count(commit_count)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_head(input logic v, input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] val, input logic [RW-1:0] id,
                          input logic mis, input logic [31:0] tgt);
    head_valid = v; head_ready = v; head_type = t; head_rd = rd;
    head_val = val; head_rob_id = id; head_mispredict = mis; head_target = tgt;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; store_done = 1'b0;
    set_head(1'b0, 2'd0, 5'd0, 32'd0, '0, 1'b0, 32'd0);
    tick(); tick();
    rst_in = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef COMMIT_STAT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({pop, commit_ready, store_req, clear, redirect_valid, halt} !== 6'b0 ||
        commit_reg_id !== 5'd0 || commit_val !== 32'd0 || commit_rob_id !== '0 ||
        store_rob_id !== '0 || redirect_pc !== 32'd0 || commit_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: pop=%b cr=%b sreq=%b clr=%b rv=%b halt=%b rpc=%h cnt=%0d, expected all 0",
               pop, commit_ready, store_req, clear, redirect_valid, halt, redirect_pc, commit_count);
    end
  endtask

  task automatic test_regwrite();
    do_reset();
    set_head(1'b1, 2'd0, 5'd5, 32'h1234, 4'd3, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b1 || commit_reg_id !== 5'd5 ||
        commit_val !== 32'h1234 || commit_rob_id !== 4'd3) begin
      n_fail++;
      $display("FAIL regwrite_c1: pop=%b cr=%b rd=%0d val=%h id=%0d, expected 1 1 5 1234 3",
               pop, commit_ready, commit_reg_id, commit_val, commit_rob_id);
    end
    tick();
    set_head(1'b1, 2'd0, 5'd0, 32'hdead, 4'd4, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL regwrite_rd0: pop=%b cr=%b, expected 1 0", pop, commit_ready);
    end
    tick();
    head_valid = 1'b1; head_ready = 1'b0;
    #1;
    n_tests++;
    if (pop !== 1'b0 || commit_ready !== 1'b0 || store_req !== 1'b0 || commit_count !== exp_cnt(32'd2)) begin
      n_fail++;
      $display("FAIL regwrite_stall_cnt: pop=%b cr=%b sreq=%b cnt=%0d, expected 0 0 0 %0d",
               pop, commit_ready, store_req, commit_count, exp_cnt(32'd2));
    end
  endtask

  task automatic test_store();
    do_reset();
    store_done = 1'b1;
    set_head(1'b1, 2'd1, 5'd9, 32'h55, 4'd7, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (store_req !== 1'b1 || pop !== 1'b0 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL store_req: sreq=%b pop=%b cr=%b, expected 1 0 0", store_req, pop, commit_ready);
    end
    tick();
    store_done = 1'b0;
    #1;
    n_tests++;
    if (store_req !== 1'b0 || store_rob_id !== 4'd7 || pop !== 1'b0) begin
      n_fail++;
      $display("FAIL store_wait: sreq=%b srid=%0d pop=%b, expected 0 7 0", store_req, store_rob_id, pop);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pop !== 1'b0 || store_req !== 1'b0) begin
        n_fail++;
        $display("FAIL store_hold%0d: pop=%b sreq=%b, expected 0 0", i, pop, store_req);
      end
    end
    tick();
    store_done = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done_pop: pop=%b cr=%b, expected 1 0", pop, commit_ready);
    end
    tick();
    store_done = 1'b1;
    set_head(1'b1, 2'd0, 5'd2, 32'h77, 4'd8, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b1 || commit_count !== exp_cnt(32'd1)) begin
      n_fail++;
      $display("FAIL store_back_to_run: pop=%b cr=%b cnt=%0d, expected 1 1 %0d",
               pop, commit_ready, commit_count, exp_cnt(32'd1));
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_head(1'b1, 2'd2, 5'd1, 32'h100, 4'd5, 1'b1, 32'h2000);
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b1 || commit_reg_id !== 5'd1 ||
        commit_val !== 32'h100 || clear !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_commit: pop=%b cr=%b rd=%0d val=%h clr=%b, expected 1 1 1 100 0",
               pop, commit_ready, commit_reg_id, commit_val, clear);
    end
    tick();
    set_head(1'b1, 2'd0, 5'd3, 32'h33, 4'd6, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (clear !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || pop !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_flush: clr=%b rv=%b rpc=%h pop=%b, expected 1 1 2000 0",
               clear, redirect_valid, redirect_pc, pop);
    end
    tick();
    n_tests++;
    if (clear !== 1'b0 || redirect_valid !== 1'b0 || pop !== 1'b1 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_resume: clr=%b rv=%b pop=%b cr=%b, expected 0 0 1 1",
               clear, redirect_valid, pop, commit_ready);
    end
    set_head(1'b1, 2'd2, 5'd0, 32'h0, 4'd1, 1'b0, 32'h9999);
    #1;
    tick();
    n_tests++;
    if (clear !== 1'b0 || redirect_pc !== 32'h2000 || pop !== 1'b1 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_rd0_ok: clr=%b rpc=%h pop=%b cr=%b, expected 0 2000 1 0",
               clear, redirect_pc, pop, commit_ready);
    end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    set_head(1'b1, 2'd1, 5'd0, 32'd0, 4'd2, 1'b0, 32'd0);
    tick();
    rdy_in = 1'b0; store_done = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b0 || store_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_low_pop: pop=%b sreq=%b, expected 0 0", pop, store_req);
    end
    tick();
    n_tests++;
    if (pop !== 1'b0 || store_rob_id !== 4'd2) begin
      n_fail++;
      $display("FAIL rdy_low_hold: pop=%b srid=%0d, expected 0 2", pop, store_rob_id);
    end
    rdy_in = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_restore: pop=%b cr=%b, expected 1 0", pop, commit_ready);
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    set_head(1'b1, 2'd3, 5'd4, 32'h4, 4'd9, 1'b0, 32'd0);
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_pop: pop=%b cr=%b halt=%b, expected 1 0 0", pop, commit_ready, halt);
    end
    tick();
    set_head(1'b1, 2'd0, 5'd4, 32'h4, 4'd10, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (halt !== 1'b1 || pop !== 1'b0 || commit_ready !== 1'b0 || store_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halted%0d: halt=%b pop=%b cr=%b sreq=%b, expected 1 0 0 0",
                 i, halt, pop, commit_ready, store_req);
      end
      tick();
    end
    rst_in = 1'b1; head_valid = 1'b0;
    tick();
    rst_in = 1'b0;
    #1;
    n_tests++;
    if (halt !== 1'b0 || pop !== 1'b0 || clear !== 1'b0 || commit_count !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_reset: halt=%b pop=%b clr=%b cnt=%0d, expected 0 0 0 0",
               halt, pop, clear, commit_count);
    end
    head_valid = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b1 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset_run: pop=%b cr=%b, expected 1 1", pop, commit_ready);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    set_head(1'b1, 2'd1, 5'd0, 32'd0, 4'd6, 1'b0, 32'd0);
    tick();
    rst_in = 1'b1; head_valid = 1'b0;
    tick();
    rst_in = 1'b0; store_done = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b0 || store_rob_id !== '0 || store_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_store: pop=%b srid=%0d sreq=%b, expected 0 0 0", pop, store_rob_id, store_req);
    end
    tick();
    n_tests++;
    if (pop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_store_late: pop=%b, expected 0", pop);
    end
  endtask

  // Model: mode is one of "idle", "awaiting store", "flushing", "stopped".
  task automatic test_random();
    bit          waiting, flushing, stopped, m_clear;
    logic [31:0] m_rpc, m_cnt;
    logic [RW-1:0] m_srid;
    bit          e_pop, e_cr, e_sreq, elig, live;
    do_reset();
    waiting = 0; flushing = 0; stopped = 0; m_clear = 0;
    m_rpc = '0; m_cnt = '0; m_srid = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_in          = ($urandom_range(0, 99) < 2);
      rdy_in          = ($urandom_range(0, 9) != 0);
      store_done      = ($urandom_range(0, 2) == 0);
      head_valid      = ($urandom_range(0, 4) != 0);
      head_ready      = ($urandom_range(0, 4) != 0);
      head_type       = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      head_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      head_val        = $urandom;
      head_rob_id     = RW'($urandom);
      head_mispredict = $urandom_range(0, 1);
      head_target     = $urandom;
      #1;
      elig = head_valid && head_ready;
      live = rdy_in && !rst_in && !stopped && !flushing;
      e_pop = 0; e_cr = 0; e_sreq = 0;
      if (live && waiting) e_pop = store_done;
      else if (live && elig) begin
        e_sreq = (head_type == 2'd1);
        e_pop  = (head_type != 2'd1);
        e_cr   = (head_type == 2'd0 || head_type == 2'd2) && head_rd != 0;
      end
      n_tests++;
      if (pop !== e_pop || commit_ready !== e_cr || store_req !== e_sreq ||
          (e_cr && (commit_reg_id !== head_rd || commit_val !== head_val || commit_rob_id !== head_rob_id))) begin
        n_fail++;
        $display("FAIL rand_comb@%0d: pop=%b cr=%b sreq=%b rd=%0d val=%h, expected %b %b %b %0d %h",
                 cyc, pop, commit_ready, store_req, commit_reg_id, commit_val,
                 e_pop, e_cr, e_sreq, head_rd, head_val);
      end
      n_tests++;
      if (clear !== m_clear || redirect_valid !== m_clear || redirect_pc !== m_rpc ||
          halt !== stopped || store_rob_id !== m_srid || commit_count !== exp_cnt(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_reg@%0d: clr=%b rv=%b rpc=%h halt=%b srid=%0d cnt=%0d, expected %b %b %h %b %0d %0d",
                 cyc, clear, redirect_valid, redirect_pc, halt, store_rob_id, commit_count,
                 m_clear, m_clear, m_rpc, stopped, m_srid, exp_cnt(m_cnt));
      end
      if (rst_in) begin
        waiting = 0; flushing = 0; stopped = 0; m_clear = 0;
        m_rpc = '0; m_cnt = '0; m_srid = '0;
      end else if (rdy_in) begin
        if (e_pop) m_cnt = m_cnt + 1;
        flushing = 0;
        m_clear  = 0;
        if (waiting && store_done) waiting = 0;
        else if (e_sreq) begin waiting = 1; m_srid = head_rob_id; end
        else if (e_pop && !waiting && head_type == 2'd2 && head_mispredict) begin
          flushing = 1; m_clear = 1; m_rpc = head_target;
        end else if (e_pop && !waiting && head_type == 2'd3) stopped = 1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_regwrite();
    test_store();
    test_mispredict();
    test_rdy_stall();
    test_halt_reset();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order commit sequencer between the reorder-buffer head and the architectural register file. Each cycle it inspects the ROB head entry. It then drives the register-file commit port, handshakes store retirement with the load/store buffer, and raises the pipeline-wide flush and redirect on branch mispredicts. It also latches program halt. It is the only writer of the regfile commit port and the only source of `clear`.

## Interface
Parameters:
- `ROB_WIDTH`, default 4: ROB index width, equal to the codebase `ROB_WIDTH`.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: ready; when low, state freezes and all pulse outputs are 0.
- `head_valid` in 1: ROB holds at least one entry.
- `head_ready` in 1: head result is available.
- `head_rob_id` in ROB_WIDTH: head index.
- `head_type` in 2: 0 = reg-write, 1 = store, 2 = branch/jump, 3 = halt.
- `head_rd` in 5: destination register.
- `head_val` in 32: result or link value.
- `head_mispredict` in 1: branch resolved opposite to prediction.
- `head_target` in 32: correct next PC for a mispredicted branch.
- `pop` out 1: dequeue the ROB head at this clock edge.
- `commit_ready` out 1: regfile write strobe.
- `commit_reg_id` out 5: regfile write register.
- `commit_val` out 32: regfile write value.
- `commit_rob_id` out ROB_WIDTH: regfile write ROB tag.
- `store_req` out 1: one-cycle pulse telling the LSB that the store at `store_rob_id` may retire.
- `store_rob_id` out ROB_WIDTH: ROB tag of the store being retired.
- `store_done` in 1: LSB finished the memory write.
- `clear` out 1: global flush pulse, registered.
- `redirect_valid` out 1: fetch redirect pulse, registered.
- `redirect_pc` out 32: fetch redirect target, registered.
- `halt` out 1: sticky halt flag.
- `commit_count` out 32: number of retired instructions.

## Operation
States: RUN, STORE_WAIT, FLUSH, HALTED. Reset enters RUN.

- The head is eligible when `head_valid && head_ready`. The signals `pop` and `commit_*` are combinational from state and head, gated by `rdy_in`. `clear`, `redirect_*`, `halt` and `store_rob_id` are registered.

RUN, with an eligible head:
- Type 0 (reg-write):
  - Assert `pop`.
  - Assert `commit_ready` with `commit_reg_id=head_rd`, `commit_val=head_val`, `commit_rob_id=head_rob_id`.
  - `head_rd==0` still pops, with `commit_ready=0`.
  - Stay in RUN.
- Type 1 (store):
  - Pulse `store_req` and latch `store_rob_id=head_rob_id`.
  - No pop; go to STORE_WAIT.
- Type 2 (branch/jump):
  - Assert `pop`, plus a commit of `head_rd` under the same rd≠0 rule.
  - If `head_mispredict`: register `clear=1`, `redirect_valid=1`, `redirect_pc=head_target` for the next cycle, then go to FLUSH. Otherwise stay in RUN.
- Type 3 (halt): assert `pop`, set `halt=1`, go to HALTED.

RUN with no eligible head: all pulse outputs are 0.

STORE_WAIT:
- `store_req` stays low.
- When `store_done` arrives: assert `pop` (no regfile commit) and return to RUN.
- The head is ignored while waiting.

FLUSH:
- Lasts exactly one cycle; `clear` and `redirect_valid` are high during it.
- The head is ignored, since the ROB is being cleared.
- Returns to RUN.

HALTED:
- Absorbing until reset.
- `halt=1`; all other pulse outputs are 0.

Boundary conditions:
- `store_done` outside STORE_WAIT is ignored.
- A non-mispredicted branch with `rd==0` pops only.
- `head_ready=0` with `head_valid=1` stalls with no outputs.
- `rdy_in` low in any state freezes the state, the registered outputs and `commit_count`. It also forces `pop`, `commit_ready` and `store_req` to 0.
- `clear`/`redirect_valid` already registered keep their values while `rdy_in` is low. They drop on the first ready cycle after FLUSH.

## Timing
- Reset values: `pop`, `commit_ready`, `store_req`, `clear`, `redirect_valid` and `halt` are 0. `commit_reg_id`, `commit_val`, `commit_rob_id`, `store_rob_id`, `redirect_pc` and `commit_count` are 0. State is RUN.
- Reset mid-STORE_WAIT or mid-FLUSH returns to RUN in the next cycle with all outputs 0. Any pending store is abandoned.
- Throughput:
  - Reg-write and non-mispredicted branch: 1 per cycle.
  - Store: 2 cycles minimum (request cycle, then `store_done` cycle).
  - Mispredict: 2 cycles (commit cycle plus FLUSH).
- `store_req` goes high in the same cycle the store head becomes eligible in RUN, for exactly 1 cycle.
- `clear` and `redirect_valid` go high in the cycle after the mispredicted branch pops, for exactly 1 cycle.
- The regfile write in the mispredict commit cycle lands before `clear` takes effect.

## Configuration
- `COMMIT_STAT_EN` defined:
  - `commit_count` increments by 1 on every cycle with `pop=1` (including `pop` on a store).
  - It wraps modulo 2^32.
- `COMMIT_STAT_EN` undefined: `commit_count` is tied to 0 and no counter is synthesized.

## Test plan
- Reg-write commits: heads rd=5, val=0x1234, id=3 and then rd=0 in consecutive cycles → cycle 1: `pop=1`, `commit_ready=1`, reg 5/0x1234/id 3; cycle 2: `pop=1`, `commit_ready=0`; with the macro on, `commit_count=2`.
- Store retirement: store head id=7 → `store_req=1` for 1 cycle with `store_rob_id=7`; `store_done` after 4 cycles → `pop=1` in that cycle only, then back to RUN.
- Mispredict: branch rd=1, val=0x100, target=0x2000 → same cycle `pop=1` and a commit to reg 1; next cycle `clear=1`, `redirect_valid=1`, `redirect_pc=0x2000`; the cycle after, both are 0 and commits resume.
- `rdy_in` stall: drop `rdy_in` during STORE_WAIT and raise `store_done` → no `pop`; restore `rdy_in` with `store_done` high → `pop=1`.
- Halt and reset: halt head → `halt=1` sticky; later eligible heads give no `pop`; `rst_in` for 1 cycle → all outputs 0 and state RUN.
- Reset mid-store: `rst_in` during STORE_WAIT → next cycle RUN; a later `store_done` causes no `pop`.
